// File: rtl/tdm_mux_pkg.sv
// Shared definitions for the 8:1 TDM multiplexer: channel count, select width
// and the slot-index type carried on out_sel.
package tdm_mux_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef logic [SEL_W-1:0] ch_sel_t;

  // Slot indices wrap naturally modulo NUM_CH because SEL_W bits cover exactly 8 slots.
  function automatic ch_sel_t next_sel(input ch_sel_t s);
    return s + ch_sel_t'(1);
  endfunction

endpackage

// File: rtl/tdm_mux_8x1_if.sv
// Stream bundle for tdm_mux_8x1: eight valid/ready input lanes merged into one
// tagged output stream. The mux side uses "master", the surrounding logic "slave".
interface tdm_mux_8x1_if #(
  parameter int W = 8
);
  import tdm_mux_pkg::*;

  logic [NUM_CH*W-1:0] in_data;
  logic [NUM_CH-1:0]   in_valid;
  logic [NUM_CH-1:0]   in_ready;
  logic [W-1:0]        out_data;
  ch_sel_t             out_sel;
  logic                out_valid;
  logic                out_ready;

  modport master (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_sel,
    output out_valid,
    input  out_ready
  );

  modport slave (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_sel,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/tdm_mux_8x1_rr_pick8.sv
// rr_pick8: combinational circular first-one finder over 8 requests, starting
// the search at base and wrapping 7 -> 0.
module rr_pick8
  import tdm_mux_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  ch_sel_t           base,
  output ch_sel_t           gnt_idx,
  output logic              any
);

  ch_sel_t idx;

  always_comb begin
    gnt_idx = base;
    idx     = base;
    // Walk from the furthest offset back to base so the nearest requester wins.
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = base + ch_sel_t'(k);
      if (req[idx]) gnt_idx = idx;
    end
  end

  assign any = |req;

endmodule

// File: rtl/tdm_mux_8x1.sv
// tdm_mux_8x1: registered round-robin 8:1 TDM merger; each beat is tagged with its
// source index. Build option TDM_MUX_SKIP_IDLE_EN selects skip-idle arbitration.
module tdm_mux_8x1
  import tdm_mux_pkg::*;
#(
  parameter int W = 8
) (
  input  logic          clk,
  input  logic          rst,
  tdm_mux_8x1_if.master bus
);

  ch_sel_t      ptr;
  ch_sel_t      grant;
  logic         offer;
  logic         load_en;
  logic         xfer;
  logic [W-1:0] grant_data;

  // The output register can take a beat when empty or being drained this cycle.
  assign load_en = !bus.out_valid || bus.out_ready;

`ifdef TDM_MUX_SKIP_IDLE_EN
  rr_pick8 u_pick (
    .req     (bus.in_valid),
    .base    (ptr),
    .gnt_idx (grant),
    .any     (offer)
  );
`else
  assign grant = ptr;
  assign offer = 1'b1;
`endif

  always_comb begin
    bus.in_ready = '0;
    if (load_en && offer && !rst) bus.in_ready[grant] = 1'b1;
  end

  assign xfer       = bus.in_valid[grant] && bus.in_ready[grant];
  assign grant_data = bus.in_data[grant*W +: W];

  // Output register stage: one beat plus its source tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sel   <= '0;
      ptr           <= '0;
    end else if (load_en) begin
      if (xfer) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= grant_data;
        bus.out_sel   <= grant;
      end else begin
        bus.out_valid <= 1'b0;
      end
`ifdef TDM_MUX_SKIP_IDLE_EN
      if (xfer) ptr <= next_sel(grant);
`else
      ptr <= next_sel(ptr);
`endif
    end
  end

endmodule

// File: tb/tb_tdm_mux_8x1.sv
// Testbench for tdm_mux_8x1: vector table, loopback, sparse-traffic sequence and
// randomized traffic against a slot-level reference model.
module tb_tdm_mux_8x1;

  typedef struct {
    logic       r;
    logic [7:0] v;
    logic       ordy;
    logic [7:0] rdy;
    logic       ov;
    logic [7:0] od;
    logic [2:0] os;
    logic [2:0] p;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [7:0] demux_y;

  vec_t tbl[23];

  logic       m_valid;
  logic [7:0] m_data;
  logic [2:0] m_sel;
  int         m_ptr;

  tdm_mux_8x1_if #(.W(8)) bus ();

  tdm_mux_8x1 #(.W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream demux stand-in: each consumed beat lands on output y[out_sel].
  always @(posedge clk)
    if (!rst && bus.out_valid && bus.out_ready) demux_y[bus.out_sel] <= bus.out_data[0];

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [7:0] v, input logic ordy,
                              input logic [7:0] rdy, input logic ov, input logic [7:0] od,
                              input logic [2:0] os, input logic [2:0] p);
    vec_t t;
    t.r = r; t.v = v; t.ordy = ordy; t.rdy = rdy;
    t.ov = ov; t.od = od; t.os = os; t.p = p;
    return t;
  endfunction

  function automatic logic [63:0] lanes(input logic [7:0] base, input logic [7:0] step);
    logic [63:0] d;
    for (int i = 0; i < 8; i++) d[i*8 +: 8] = base + step * 8'(i);
    return d;
  endfunction

  // One cycle of randomized traffic checked against the slot-level model.
  task automatic model_cycle(input logic r, input logic [7:0] v, input logic [63:0] d,
                             input logic ordy);
    int         g;
    logic       ld;
    logic       off;
    logic       xf;
    logic [7:0] er;
    rst = r; bus.in_valid = v; bus.in_data = d; bus.out_ready = ordy;
    @(negedge clk);
    g = m_ptr;
`ifdef TDM_MUX_SKIP_IDLE_EN
    for (int k = 7; k >= 0; k--) if (v[(m_ptr + k) % 8]) g = (m_ptr + k) % 8;
    off = (v != 8'h00);
`else
    off = 1'b1;
`endif
    ld  = !m_valid || ordy;
    off = off && ld && !r;
    er  = off ? 8'(1 << g) : 8'h00;
    chk("rnd_in_ready", 64'(bus.in_ready), 64'(er));
    xf = off && v[g];
    if (r) begin
      m_valid = 1'b0; m_data = 8'h00; m_sel = 3'd0; m_ptr = 0;
    end else if (ld) begin
      if (xf) begin
        m_valid = 1'b1; m_data = d[g*8 +: 8]; m_sel = 3'(g);
      end else begin
        m_valid = 1'b0;
      end
`ifdef TDM_MUX_SKIP_IDLE_EN
      if (xf) m_ptr = (g + 1) % 8;
`else
      m_ptr = (m_ptr + 1) % 8;
`endif
    end
    @(posedge clk); #1;
    chk("rnd_out_valid", 64'(bus.out_valid), 64'(m_valid));
    if (m_valid) begin
      chk("rnd_out_data", 64'(bus.out_data), 64'(m_data));
      chk("rnd_out_sel", 64'(bus.out_sel), 64'(m_sel));
    end
    chk("rnd_ptr", 64'(dut.ptr), 64'(m_ptr));
  endtask

  initial begin
    checks = 0; errors = 0;
    demux_y = 8'h55;
    rst = 1'b1;
    bus.in_valid = 8'h00; bus.in_data = '0; bus.out_ready = 1'b1;

    tbl[0] = mk(1, 8'hFF, 1, 8'h00, 0, 8'h00, 3'd0, 3'd0);
    tbl[1] = mk(1, 8'hFF, 1, 8'h00, 0, 8'h00, 3'd0, 3'd0);
    for (int k = 0; k < 12; k++)
      tbl[2+k] = mk(0, 8'hFF, 1, 8'(1 << (k % 8)), 1, 8'hA0 + 8'(k % 8), 3'(k % 8),
                    3'((k % 8) + 1));
    for (int k = 14; k < 19; k++) tbl[k] = mk(0, 8'hFF, 0, 8'h00, 1, 8'hA3, 3'd3, 3'd4);
    tbl[19] = mk(0, 8'hFF, 1, 8'h10, 1, 8'hA4, 3'd4, 3'd5);
    tbl[20] = mk(0, 8'hFF, 1, 8'h20, 1, 8'hA5, 3'd5, 3'd6);
    tbl[21] = mk(1, 8'hFF, 1, 8'h00, 0, 8'h00, 3'd0, 3'd0);
    tbl[22] = mk(0, 8'hFF, 1, 8'h01, 1, 8'hA0, 3'd0, 3'd1);

    // Reset, full load with wrap, backpressure hold and mid-stream reset.
    bus.in_data = lanes(8'hA0, 8'h01);
    for (int i = 0; i < 23; i++) begin
      rst = tbl[i].r; bus.in_valid = tbl[i].v; bus.out_ready = tbl[i].ordy;
      @(negedge clk);
      chk($sformatf("tbl%0d_in_ready", i), 64'(bus.in_ready), 64'(tbl[i].rdy));
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_out_valid", i), 64'(bus.out_valid), 64'(tbl[i].ov));
      chk($sformatf("tbl%0d_out_data", i), 64'(bus.out_data), 64'(tbl[i].od));
      chk($sformatf("tbl%0d_out_sel", i), 64'(bus.out_sel), 64'(tbl[i].os));
      chk($sformatf("tbl%0d_ptr", i), 64'(dut.ptr), 64'(tbl[i].p));
    end

    // Loopback: channel i carries i, so bit 0 routed by out_sel must match the slot.
    bus.in_data = lanes(8'h00, 8'h01);
    for (int j = 0; j < 9; j++) begin
      @(posedge clk); #1;
      chk("loop_sel", 64'(bus.out_sel), 64'((1 + j) % 8));
      chk("loop_data", 64'(bus.out_data), 64'((1 + j) % 8));
    end
    @(negedge clk);
    chk("loop_demux_y", 64'(demux_y), 64'h0AA);

    // Sparse traffic: only channel 5 requests.
    rst = 1'b1;
    bus.in_valid = 8'h20;
    bus.in_data = 64'h0000_5500_0000_0000;
    @(negedge clk);
    chk("sparse_rst_in_ready", 64'(bus.in_ready), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int t = 0; t < 16; t++) begin
      logic       ev;
      logic [7:0] er;
`ifdef TDM_MUX_SKIP_IDLE_EN
      ev = 1'b1; er = 8'h20;
`else
      ev = ((t % 8) == 5); er = 8'(1 << (t % 8));
`endif
      @(negedge clk);
      chk($sformatf("sparse%0d_in_ready", t), 64'(bus.in_ready), 64'(er));
      @(posedge clk); #1;
      chk($sformatf("sparse%0d_out_valid", t), 64'(bus.out_valid), 64'(ev));
      if (ev) begin
        chk($sformatf("sparse%0d_out_data", t), 64'(bus.out_data), 64'h55);
        chk($sformatf("sparse%0d_out_sel", t), 64'(bus.out_sel), 64'd5);
      end
    end

    // Randomized traffic against the reference model.
    m_valid = 1'b0; m_data = 8'h00; m_sel = 3'd0; m_ptr = 0;
    model_cycle(1'b1, 8'hFF, lanes(8'h10, 8'h11), 1'b1);
    for (int n = 0; n < 600; n++) begin
      logic [7:0]  v;
      logic [63:0] d;
      v = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 3) == 0) v = 8'($urandom);
      d = {$urandom, $urandom};
      model_cycle(($urandom_range(0, 60) == 0), v, d, ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_mux_8x1.md
# tdm_mux_8x1

Registered, round-robin 8-to-1 time-division multiplexer. It is the transmit-side counterpart of the 8x1 demultiplexer. Eight valid/ready input channels are merged onto one output stream, and each output beat is tagged with its 3-bit source index (`out_sel`). `out_sel` drives the select of a downstream `demux_8x1`, so each beat can be routed back to the matching output channel.

## Interface
- `W`, default 8: data width per channel.
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: synchronous, active-high reset.
- `in_data`, input, 8*W: channel i occupies bits [i*W +: W].
- `in_valid`, input, 8: per-channel valid.
- `in_ready`, output, 8: per-channel ready, one-hot or zero.
- `out_data`, output, W: registered output data.
- `out_sel`, output, 3: registered source channel index of `out_data`.
- `out_valid`, output, 1: registered output valid.
- `out_ready`, input, 1: downstream ready.

## Operation
- Single output register (holding one beat) plus a 3-bit scan pointer `ptr`.
- `load_en` = `!out_valid || out_ready`. The register can accept a beat when it is empty or is being drained in the same cycle.
- `grant` is the channel offered this cycle:
  - In fixed-slot mode, `grant = ptr`.
  - In skip-idle mode, `grant` is the first channel with `in_valid` set, scanning circularly from `ptr`.
- `in_ready[i] = load_en && (i == grant) && !rst`. In skip-idle mode, additionally require that at least one `in_valid` bit is set.
- An input transfer occurs on `in_valid[grant] && in_ready[grant]`. On a transfer the register loads `out_data <= in_data[grant]`, `out_sel <= grant`, `out_valid <= 1`.
- If `load_en` is set and no transfer occurs, `out_valid <= 0` (the beat drained, nothing replaced it).
- If `load_en` is clear, the register holds: `out_data`, `out_sel` and `out_valid` stay stable and `ptr` is frozen.
- Pointer update when `load_en` is set:
  - Fixed-slot mode: `ptr <= ptr + 1` every cycle, whether or not the slot was used.
  - Skip-idle mode: `ptr <= grant + 1` on a transfer; otherwise `ptr` holds.
  - Wrap-around is modulo 8 (7 -> 0).
- Simultaneous drain and load (`out_valid && out_ready` together with an input transfer) gives back-to-back beats with no bubble.
- Reset values: `out_valid=0`, `out_data=0`, `out_sel=0`, `ptr=0`, `in_ready=0`.
- Reset asserted mid-operation discards any held beat. No handshake completes in a reset cycle.

## Timing
- Latency is 1 cycle: an input accepted at edge N appears on `out_*` after edge N.
- `in_ready` is combinational from `out_valid`, `out_ready`, `ptr` and (skip-idle only) `in_valid`. There is no path from `in_data`.
- Peak throughput is 1 beat per cycle.
- Fixed-slot mode: a lone active channel is served at most once every 8 cycles. The worst-case wait is 7 cycles plus any stall time.
- Skip-idle mode: under full load, each active channel is served within N_active cycles (starvation-free), stall cycles excluded.

## Configuration
- Macro: `TDM_MUX_SKIP_IDLE_EN`.
- Defined: work-conserving round-robin. Idle channels are skipped and `ptr` advances to just past the served channel.
- Undefined: strict fixed-slot TDM. One slot per `load_en` cycle, and empty slots waste output bandwidth. This mode keeps the slot timing deterministic for a downstream demux.

## Structure
- Shared package `tdm_mux_pkg`: `NUM_CH=8`, `SEL_W=3`, and the slot-index typedef `ch_sel_t` (logic [2:0]).
- Natural sub-module: `rr_pick8`.
  - Combinational circular first-one finder.
  - Inputs: `req[7:0]`, `base[2:0]`. Outputs: `gnt_idx[2:0]`, `any`.
  - Instantiated only under `TDM_MUX_SKIP_IDLE_EN`.

## Test plan
All scenarios use W=8.
- **Reset.** Hold `rst=1` for 2 cycles with all `in_valid=1` -> `out_valid=0`, `out_data=0`, `out_sel=0`, `in_ready=0` throughout. After release, the first grant is channel 0.
- **Full load.** All `in_valid=1`, channel i data = 8'hA0+i, `out_ready=1` -> `out_data` A0..A7 on consecutive cycles with `out_sel` 0..7, then wraps to A0/0. Must hold in both modes.
- **Sparse traffic.** Only channel 5 valid (data 8'h55), `out_ready=1`:
  - Fixed-slot: 8'h55/`out_sel=5` appears once every 8 cycles, first on the cycle after `ptr=5`.
  - Skip-idle: a new beat every cycle.
- **Backpressure.** `out_ready=0` while holding 8'hA3/`out_sel=3` for 5 cycles -> output stable, `in_ready=0`, `ptr` frozen at 4. Raising `out_ready` gives A4 on the next cycle with no bubble.
- **Reset mid-stream.** Assert `rst` while `out_valid=1` -> next cycle `out_valid=0` and `ptr=0`. No `in_ready` is asserted during reset.
- **Loopback.** `out_sel` and bit 0 of `out_data` drive `demux_8x1` sel and `a`, with channel i data = i[0] -> each demux output y[out_sel] matches the source channel's bit 0 for every slot.
